// File: rtl/mc_pred_buf.sv
`default_nettype none
// ============================================================================
// Module   : mc_pred_buf
// Brief    : Ping-pong buffer between motion compensation and the TQ reader.
//            Two banks of 12 prediction entries, each tracked by a state and
//            a written-entry mask.
// Revision : 1.0 - initial release
// ============================================================================
module mc_pred_buf #(
    parameter int BIT_DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [32*BIT_DEPTH-1:0]   mc_pred_data_i,
    input  logic [3:0]                mc_pred_addr_i,
    input  logic                      mc_pred_rdy_i,
    input  logic                      done_mc_i,
    output logic                      wr_bank_free_o,
    output logic                      tq_mb_vld_o,
    input  logic                      tq_rden_i,
    input  logic [3:0]                tq_addr_i,
    output logic [32*BIT_DEPTH-1:0]   tq_data_o,
    output logic                      tq_data_vld_o,
    input  logic                      tq_rel_i,
    output logic [1:0]                err_o
);

    localparam int c_DATA_W = 32 * BIT_DEPTH;

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_READY = 2'd2
    } bank_st_t;

    bank_st_t               r_st      [2];
    bank_st_t               w_st_nxt  [2];
    logic [11:0]            r_mask    [2];
    logic [11:0]            w_mask_nxt[2];
    logic                   r_wp;
    logic                   r_rp;
    logic                   w_wp_nxt;
    logic                   w_rp_nxt;
    logic [1:0]             r_err;
    logic [1:0]             w_err_nxt;
    logic [c_DATA_W-1:0]    r_mem [0:1][0:11];
    logic [c_DATA_W-1:0]    r_rd_data;
    logic                   r_rd_vld;

    logic                   w_wp_ready;
    logic                   w_rp_ready;
    logic                   w_wr_en;
    logic                   w_done_en;
    logic                   w_rel_en;
    logic [11:0]            w_wr_bit;
    logic [11:0]            w_wp_mask;
    logic                   w_rd_hit;

    assign w_wp_ready = (r_st[r_wp] == BANK_READY);
    assign w_rp_ready = (r_st[r_rp] == BANK_READY);
    assign w_wr_en    = mc_pred_rdy_i && (mc_pred_addr_i < 4'd12) && !w_wp_ready;
    assign w_done_en  = done_mc_i && !w_wp_ready;
    assign w_rel_en   = tq_rel_i && w_rp_ready;
    assign w_wr_bit   = w_wr_en ? (12'd1 << mc_pred_addr_i) : 12'd0;
    // Mask as it will be after this cycle's write, so a same-cycle done sees it
    assign w_wp_mask  = r_mask[r_wp] | w_wr_bit;
    assign w_rd_hit   = (tq_addr_i < 4'd12) && r_mask[r_rp][tq_addr_i];

    // Release only ever targets a READY bank while write/done target a
    // non-READY one, so the two updates never collide on the same bank.
    always_comb begin
        w_st_nxt   = r_st;
        w_mask_nxt = r_mask;
        w_wp_nxt   = r_wp;
        w_rp_nxt   = r_rp;
        w_err_nxt  = r_err;
        if (w_wr_en) begin
            w_mask_nxt[r_wp] = w_wp_mask;
            if (r_st[r_wp] == BANK_FREE)
                w_st_nxt[r_wp] = BANK_FILL;
        end
        if (w_done_en) begin
            w_st_nxt[r_wp] = BANK_READY;
            w_wp_nxt       = ~r_wp;
            if (w_wp_mask != 12'hFFF)
                w_err_nxt[1] = 1'b1;
        end
        if (w_rel_en) begin
            w_st_nxt[r_rp]   = BANK_FREE;
            w_mask_nxt[r_rp] = 12'd0;
            w_rp_nxt         = ~r_rp;
        end
        if ((mc_pred_rdy_i && !w_wr_en) || (done_mc_i && w_wp_ready))
            w_err_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < 2; b++) begin
                r_st[b]   <= BANK_FREE;
                r_mask[b] <= 12'd0;
            end
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_err <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_st[b]   <= w_st_nxt[b];
                r_mask[b] <= w_mask_nxt[b];
            end
            r_wp  <= w_wp_nxt;
            r_rp  <= w_rp_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Storage is not reset; the masks alone decide what is readable.
    always_ff @(posedge clk_i) begin
        if (w_wr_en)
            r_mem[r_wp][mc_pred_addr_i] <= mc_pred_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else if (tq_rden_i && w_rp_ready) begin
            r_rd_vld  <= 1'b1;
            r_rd_data <= w_rd_hit ? r_mem[r_rp][tq_addr_i] : '0;
        end else begin
            r_rd_vld  <= 1'b0;
        end
    end

    assign wr_bank_free_o = !w_wp_ready;
    assign tq_mb_vld_o    = w_rp_ready;
    assign tq_data_o      = r_rd_data;
    assign tq_data_vld_o  = r_rd_vld;
    assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_pred_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_pred_buf
// Brief    : Directed plus randomized bench for mc_pred_buf against a
//            queue-of-macroblocks reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_pred_buf;

    localparam int c_BD = 8;
    localparam int c_DW = 32 * c_BD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [c_DW-1:0] mc_data = '0;
    logic [3:0]      mc_addr = '0;
    logic            mc_rdy = 1'b0;
    logic            done = 1'b0;
    logic            rden = 1'b0;
    logic [3:0]      raddr = '0;
    logic            rel = 1'b0;
    logic            wr_free;
    logic            mb_vld;
    logic [c_DW-1:0] rd_data;
    logic            rd_vld;
    logic [1:0]      err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the MB being filled, plus a FIFO of completed MBs.
    logic [12*c_DW-1:0] q_data[$];
    logic [11:0]        q_mask[$];
    logic [c_DW-1:0]    f_d [12];
    logic [11:0]        f_m;
    logic [c_DW-1:0]    m_data;
    logic               m_vld;
    logic [1:0]         m_err;

    mc_pred_buf #(.BIT_DEPTH(c_BD)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .mc_pred_data_i (mc_data),
        .mc_pred_addr_i (mc_addr),
        .mc_pred_rdy_i  (mc_rdy),
        .done_mc_i      (done),
        .wr_bank_free_o (wr_free),
        .tq_mb_vld_o    (mb_vld),
        .tq_rden_i      (rden),
        .tq_addr_i      (raddr),
        .tq_data_o      (rd_data),
        .tq_data_vld_o  (rd_vld),
        .tq_rel_i       (rel),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_mask.delete();
        f_m    = 12'd0;
        m_data = '0;
        m_vld  = 1'b0;
        m_err  = 2'b00;
    endtask

    task automatic model_apply();
        logic [12*c_DW-1:0] tmp;
        int                 pre;
        if (!rst_n) begin
            model_reset();
        end else begin
            pre = q_data.size();
            if (rden && pre > 0) begin
                m_vld = 1'b1;
                tmp   = q_data[0];
                if (raddr < 12 && q_mask[0][raddr])
                    m_data = tmp[int'(raddr)*c_DW +: c_DW];
                else
                    m_data = '0;
            end else begin
                m_vld = 1'b0;
            end
            if (mc_rdy) begin
                if (mc_addr < 12 && pre < 2) begin
                    f_d[mc_addr]  = mc_data;
                    f_m[mc_addr]  = 1'b1;
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            if (done) begin
                if (pre == 2) begin
                    m_err[0] = 1'b1;
                end else begin
                    for (int i = 0; i < 12; i++)
                        tmp[i*c_DW +: c_DW] = f_d[i];
                    q_data.push_back(tmp);
                    q_mask.push_back(f_m);
                    if (f_m != 12'hFFF)
                        m_err[1] = 1'b1;
                    f_m = 12'd0;
                end
            end
            if (rel && pre > 0) begin
                void'(q_data.pop_front());
                void'(q_mask.pop_front());
            end
        end
    endtask

    task automatic check_all();
        chk("wr_bank_free", c_DW'(wr_free), c_DW'(q_data.size() < 2));
        chk("tq_mb_vld",    c_DW'(mb_vld),  c_DW'(q_data.size() > 0));
        chk("tq_data_vld",  c_DW'(rd_vld),  c_DW'(m_vld));
        chk("tq_data",      rd_data,        m_data);
        chk("err",          c_DW'(err),     c_DW'(m_err));
    endtask

    task automatic idle();
        mc_rdy = 1'b0;
        done   = 1'b0;
        rden   = 1'b0;
        rel    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [c_DW-1:0] rnd_data();
        logic [c_DW-1:0] d;
        for (int i = 0; i < c_DW / 32; i++)
            d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [c_DW-1:0] d);
        mc_rdy  = 1'b1;
        mc_addr = a;
        mc_data = d;
        tick();
        mc_rdy  = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rden  = 1'b1;
        raddr = a;
        tick();
        rden  = 1'b0;
    endtask

    task automatic release_mb();
        rel = 1'b1;
        tick();
        rel = 1'b0;
    endtask

    logic [c_DW-1:0] x_data;
    logic [7:0]      pix;

    initial begin
        model_reset();
        // Reset values
        do_reset();
        chk("rst_wr_free", c_DW'(wr_free), c_DW'(1'b1));
        chk("rst_mb_vld",  c_DW'(mb_vld),  c_DW'(1'b0));
        chk("rst_err",     c_DW'(err),     c_DW'(2'b00));

        // Full MB with addr-replicated data, read entry 5
        for (int a = 0; a < 12; a++) begin
            pix = 8'(a);
            wr(4'(a), {32{pix}});
        end
        pulse_done();
        chk("mb1_vld", c_DW'(mb_vld), c_DW'(1'b1));
        rd(4'd5);
        chk("mb1_rd_vld",  c_DW'(rd_vld), c_DW'(1'b1));
        chk("mb1_rd_data", rd_data, {32{8'h05}});
        chk("mb1_err",     c_DW'(err), c_DW'(2'b00));
        release_mb();
        chk("mb1_released", c_DW'(mb_vld), c_DW'(1'b0));

        // Two MBs without release, then an overflow write
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 12; a++)
                wr(4'(a), rnd_data());
            pulse_done();
        end
        chk("full_wr_free", c_DW'(wr_free), c_DW'(1'b0));
        wr(4'd3, rnd_data());
        chk("full_drop_err", c_DW'(err), c_DW'(2'b01));
        pulse_done();
        chk("full_done_err", c_DW'(err), c_DW'(2'b01));
        rd(4'd11);
        rd(4'd0);

        // Incomplete MB
        do_reset();
        for (int a = 0; a < 8; a++)
            wr(4'(a), rnd_data());
        pulse_done();
        chk("part_vld", c_DW'(mb_vld), c_DW'(1'b1));
        chk("part_err", c_DW'(err), c_DW'(2'b10));
        rd(4'd9);
        chk("part_rd9", rd_data, '0);
        rd(4'd14);
        chk("part_rd14", rd_data, '0);

        // Release bank 0 while writing bank 1
        do_reset();
        for (int a = 0; a < 12; a++)
            wr(4'(a), rnd_data());
        pulse_done();
        for (int a = 0; a < 4; a++)
            wr(4'(a), rnd_data());
        x_data  = rnd_data();
        rel     = 1'b1;
        rden    = 1'b1;
        raddr   = 4'd2;
        mc_rdy  = 1'b1;
        mc_addr = 4'd4;
        mc_data = x_data;
        tick();
        idle();
        chk("rel_wr_mb_vld",  c_DW'(mb_vld),  c_DW'(1'b0));
        chk("rel_wr_free",    c_DW'(wr_free), c_DW'(1'b1));
        chk("rel_wr_rd_vld",  c_DW'(rd_vld),  c_DW'(1'b1));
        for (int a = 5; a < 12; a++)
            wr(4'(a), rnd_data());
        pulse_done();
        rd(4'd4);
        chk("rel_wr_data", rd_data, x_data);
        chk("rel_wr_err",  c_DW'(err), c_DW'(2'b00));

        // Read with no MB available
        do_reset();
        rd(4'd1);
        chk("idle_rd_vld", c_DW'(rd_vld), c_DW'(1'b0));

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            mc_rdy  = ($urandom_range(0, 1) == 1);
            mc_addr = 4'($urandom_range(0, 13));
            mc_data = rnd_data();
            done    = ($urandom_range(0, 9) == 0);
            rden    = ($urandom_range(0, 1) == 1);
            raddr   = 4'($urandom_range(0, 15));
            rel     = ($urandom_range(0, 11) == 0);
            tick();
            if (c == 700) begin
                idle();
                do_reset();
            end
        end
        idle();

        // Asynchronous reset in the middle of a fill
        do_reset();
        for (int a = 0; a < 12; a++)
            wr(4'(a), rnd_data());
        pulse_done();
        wr(4'd0, rnd_data());
        rd(4'd3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_wr_free", c_DW'(wr_free), c_DW'(1'b1));
        chk("arst_mb_vld",  c_DW'(mb_vld),  c_DW'(1'b0));
        chk("arst_rd_vld",  c_DW'(rd_vld),  c_DW'(1'b0));
        chk("arst_data",    rd_data, '0);
        tick();
        rst_n = 1'b1;
        rd(4'd3);
        chk("arst_post_rd", c_DW'(rd_vld), c_DW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_pred_buf.md
MC_PRED_BUF -- requirements
Module: mc_pred_buf

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, bits per pixel.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mc_pred_data_i  input  32*BIT_DEPTH  one prediction row-group from MC.
REQ-005 SHALL have port mc_pred_addr_i  input  4  entry index; 0..7 luma, 8..11 chroma.
REQ-006 SHALL have port mc_pred_rdy_i  input  1  write strobe, one entry per cycle.
REQ-007 SHALL have port done_mc_i  input  1  single-cycle pulse: current MB fully written.
REQ-008 SHALL have port wr_bank_free_o  output  1  producer may start or continue an MB.
REQ-009 SHALL have port tq_mb_vld_o  output  1  a completed MB is readable.
REQ-010 SHALL have port tq_rden_i  input  1  read request.
REQ-011 SHALL have port tq_addr_i  input  4  read entry index.
REQ-012 SHALL have port tq_data_o  output  32*BIT_DEPTH  read data.
REQ-013 SHALL have port tq_data_vld_o  output  1  tq_data_o valid this cycle.
REQ-014 SHALL have port tq_rel_i  input  1  reader releases the current MB bank.
REQ-015 SHALL have port err_o  output  2  sticky: [0] write dropped, [1] MB closed incomplete.

Function
REQ-016 SHALL hold two banks (ping-pong), each 12 entries x 32*BIT_DEPTH, with a 12-bit written mask per bank.
REQ-017 Each bank SHALL be in one of FREE, FILL, READY; write pointer wp and read pointer rp, 1 bit each.
REQ-018 A write (mc_pred_rdy_i=1) to bank wp in FREE or FILL SHALL store the data, set the mask bit, and move FREE->FILL.
REQ-019 Writes with addr 12..15, or while bank wp is READY, SHALL be dropped and SHALL set err_o[0].
REQ-020 done_mc_i SHALL move bank wp to READY and toggle wp in the same edge; a write in that same cycle SHALL be stored first.
REQ-021 done_mc_i with a mask of bank wp not equal to 12'hFFF (including a FREE bank) SHALL still close the bank and set err_o[1].
REQ-022 done_mc_i while bank wp is READY SHALL be ignored and SHALL set err_o[0].
REQ-023 wr_bank_free_o SHALL be combinational: 1 when bank wp is not READY.
REQ-024 tq_mb_vld_o SHALL be combinational: 1 when bank rp is READY.
REQ-025 tq_rden_i while tq_mb_vld_o=1 SHALL give tq_data_vld_o=1 and registered tq_data_o one cycle later (latency 1).
REQ-026 Read data for addr 12..15 or an unwritten entry SHALL be all zero.
REQ-027 Read requests while tq_mb_vld_o=0 SHALL be ignored; tq_data_vld_o=0 next cycle and tq_data_o holds its value.
REQ-028 tq_rel_i while tq_mb_vld_o=1 SHALL set bank rp to FREE, clear its mask, and toggle rp; otherwise tq_rel_i is ignored.
REQ-029 A read in the release cycle SHALL return data from the released bank.
REQ-030 Release of one bank and a write or done to the other bank in the same cycle SHALL both take effect.
REQ-031 Release and done_mc_i in the same cycle with wp==rp SHALL free the bank and drop the done (err_o[0] set).
REQ-032 Back-to-back reads SHALL be supported at one per cycle; write and read paths SHALL be independent.

Reset
REQ-033 On rst_n_i low: both banks FREE, wp=rp=0, masks 0.
REQ-034 On rst_n_i low: tq_data_o=0, tq_data_vld_o=0, err_o=0; thus wr_bank_free_o=1 and tq_mb_vld_o=0.
REQ-035 Reset mid-MB SHALL discard all buffered data; storage arrays need not be cleared.

Verification
REQ-036 Reset, write addr 0..11 with data=addr replicated, pulse done -> tq_mb_vld_o=1; read addr 5 -> next cycle tq_data_vld_o=1, data=5s; err_o=0.
REQ-037 Fill two MBs without release -> wr_bank_free_o=0; a further write -> dropped, err_o=2'b01.
REQ-038 Write only addr 0..7, then done -> bank READY, err_o[1]=1; read addr 9 -> zero data.
REQ-039 Reader on bank 0 releases while the writer writes bank 1 in the same cycle -> both effects occur; rp=1; bank 0 FREE.
REQ-040 Read with tq_mb_vld_o=0 -> tq_data_vld_o stays 0; assert reset mid-fill -> all outputs return to their reset values.
